control_seq: RTL and testbench

Multicycle control sequencer; the next generation of the single-cycle opcode decoder, which it supersedes. It decodes the same opcode classes (OP, IMM, LOAD, STORE, BRANCH) and sequences each instruction through fetch, decode, execute, memory and writeback. It adds memory wait-state handshaking, a parametrised multi-cycle M-extension multiply wait, a memory timeout and a sticky illegal-instruction trap. It sits between the instruction register/register file/ALU datapath and the unified memory port.

---
 rtl/control_seq_if.sv | 35 +++
 rtl/control_seq.sv | 247 ++++++++++++++++++++++++
 tb/tb_control_seq.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/control_seq_if.sv
// Datapath/memory-port bundle of the multicycle control sequencer.
// The master side is the sequencer; the slave side is the datapath and memory port.
interface control_seq_if;
  logic       Start_i;
  logic [6:0] Opcode_i;
  logic [6:0] Funct7_i;
  logic       Zero_i;
  logic       MemReady_i;
  logic       PCWrite_o;
  logic       IRWrite_o;
  logic       RegWrite_o;
  logic       MemRead_o;
  logic       MemWrite_o;
  logic       MemToReg_o;
  logic       ALUSrc_o;
  logic       IorD_o;
  logic       PCSrc_o;
  logic [1:0] ALUOp_o;
  logic       Busy_o;
  logic       Illegal_o;
  logic       Timeout_o;
  logic [3:0] State_o;

  modport master (
    input  Start_i, Opcode_i, Funct7_i, Zero_i, MemReady_i,
    output PCWrite_o, IRWrite_o, RegWrite_o, MemRead_o, MemWrite_o, MemToReg_o,
           ALUSrc_o, IorD_o, PCSrc_o, ALUOp_o, Busy_o, Illegal_o, Timeout_o, State_o
  );

  modport slave (
    output Start_i, Opcode_i, Funct7_i, Zero_i, MemReady_i,
    input  PCWrite_o, IRWrite_o, RegWrite_o, MemRead_o, MemWrite_o, MemToReg_o,
           ALUSrc_o, IorD_o, PCSrc_o, ALUOp_o, Busy_o, Illegal_o, Timeout_o, State_o
  );
endinterface

// File: rtl/control_seq.sv
// Multicycle control sequencer: fetch/decode/execute/memory/writeback with memory
// wait states, multi-cycle multiply wait, memory timeout and sticky illegal-opcode trap.
module control_seq #(
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input logic           clk_i,
  input logic           rst_i,
  control_seq_if.master bus
);

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_IMM    = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] FUNCT7_MEXT   = 7'b0000001;

  localparam logic [1:0] ALU_OP_STR = 2'b00;
  localparam logic [1:0] ALU_OP_REG = 2'b10;
  localparam logic [1:0] ALU_OP_IMM = 2'b11;

  localparam bit         MUL_MULTI    = (MUL_LATENCY > 32'd1);
  localparam logic [3:0] MUL_LOAD     = MUL_MULTI ? 4'(MUL_LATENCY - 32'd2) : 4'd0;
  localparam bit         TIMEOUT_EN   = (MEM_TIMEOUT != 32'd0);
  localparam logic [8:0] TIMEOUT_LIM  = 9'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MULW   = 4'd4,
    S_MEM    = 4'd5,
    S_WB     = 4'd6,
    S_BRANCH = 4'd7,
    S_TRAP   = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    C_NONE   = 3'd0,
    C_OP     = 3'd1,
    C_MUL    = 3'd2,
    C_IMM    = 3'd3,
    C_LOAD   = 3'd4,
    C_STORE  = 3'd5,
    C_BRANCH = 3'd6
  } class_t;

  function automatic class_t decode_class(input logic [6:0] op, input logic [6:0] f7);
    case (op)
      OPCODE_OP:     decode_class = (f7 == FUNCT7_MEXT) ? C_MUL : C_OP;
      OPCODE_IMM:    decode_class = C_IMM;
      OPCODE_LOAD:   decode_class = C_LOAD;
      OPCODE_STORE:  decode_class = C_STORE;
      OPCODE_BRANCH: decode_class = C_BRANCH;
      default:       decode_class = C_NONE;
    endcase
  endfunction

  function automatic logic [1:0] class_alu_op(input class_t cls);
    case (cls)
      C_IMM, C_LOAD: class_alu_op = ALU_OP_IMM;
      C_STORE:       class_alu_op = ALU_OP_STR;
      default:       class_alu_op = ALU_OP_REG;
    endcase
  endfunction

  function automatic logic class_alu_src(input class_t cls);
    case (cls)
      C_IMM, C_LOAD, C_STORE: class_alu_src = 1'b1;
      default:                class_alu_src = 1'b0;
    endcase
  endfunction

  state_t     r_state;
  class_t     r_class;
  logic [3:0] r_mul_cnt;
  logic [7:0] r_wait_cnt;
  logic       r_illegal;
  logic       r_timeout;

  class_t     w_dec_class;
  state_t     w_end_state;
  logic       w_wait_expired;

  logic       w_pc_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_mem_to_reg;
  logic       w_alu_src;
  logic       w_iord;
  logic       w_pc_src;
  logic [1:0] w_alu_op;

  assign w_dec_class = decode_class(bus.Opcode_i, bus.Funct7_i);
  assign w_end_state = bus.Start_i ? S_FETCH : S_IDLE;

  // Expiry fires on the wait cycle that would bring the counter up to the limit.
  assign w_wait_expired = TIMEOUT_EN && !bus.MemReady_i &&
                          (({1'b0, r_wait_cnt} + 9'd1) == TIMEOUT_LIM);

  // Sequencer state, class register, multiply/wait counters and sticky flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_class    <= C_NONE;
      r_mul_cnt  <= 4'd0;
      r_wait_cnt <= 8'd0;
      r_illegal  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.Start_i) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= 8'd0;
          end
        end
        S_FETCH: begin
          if (bus.MemReady_i) begin
            r_state <= S_DECODE;
          end else if (w_wait_expired) begin
            r_state   <= S_TRAP;
            r_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          r_class <= w_dec_class;
          case (w_dec_class)
            C_BRANCH: r_state <= S_BRANCH;
            C_NONE: begin
              r_state   <= S_TRAP;
              r_illegal <= 1'b1;
            end
            default:  r_state <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (r_class)
            C_MUL: begin
              if (MUL_MULTI) begin
                r_state   <= S_MULW;
                r_mul_cnt <= MUL_LOAD;
              end else begin
                r_state <= S_WB;
              end
            end
            C_LOAD, C_STORE: begin
              r_state    <= S_MEM;
              r_wait_cnt <= 8'd0;
            end
            default: r_state <= S_WB;
          endcase
        end
        S_MULW: begin
          if (r_mul_cnt == 4'd0) begin
            r_state <= S_WB;
          end else begin
            r_mul_cnt <= r_mul_cnt - 4'd1;
          end
        end
        S_MEM: begin
          if (bus.MemReady_i) begin
            r_wait_cnt <= 8'd0;
            r_state    <= (r_class == C_LOAD) ? S_WB : w_end_state;
          end else if (w_wait_expired) begin
            r_state   <= S_TRAP;
            r_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_WB, S_BRANCH: begin
          r_state    <= w_end_state;
          r_wait_cnt <= 8'd0;
        end
        S_TRAP: r_state <= S_TRAP;
        default: r_state <= S_TRAP;
      endcase
    end
  end

  // Mealy strobe decode from state, class register, Zero_i and MemReady_i.
  always_comb begin
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src    = 1'b0;
    w_iord       = 1'b0;
    w_pc_src     = 1'b0;
    w_alu_op     = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        w_ir_write = bus.MemReady_i;
        w_pc_write = bus.MemReady_i;
      end
      S_EXEC, S_MULW: begin
        w_alu_op  = class_alu_op(r_class);
        w_alu_src = class_alu_src(r_class);
      end
      S_MEM: begin
        w_iord      = 1'b1;
        w_alu_op    = class_alu_op(r_class);
        w_alu_src   = class_alu_src(r_class);
        w_mem_read  = (r_class == C_LOAD);
        w_mem_write = (r_class == C_STORE);
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = (r_class == C_LOAD);
      end
      S_BRANCH: begin
        w_alu_op   = ALU_OP_REG;
        w_pc_src   = 1'b1;
        w_pc_write = bus.Zero_i;
      end
      default: begin
        w_alu_op = 2'b00;
      end
    endcase
  end

  assign bus.PCWrite_o  = w_pc_write;
  assign bus.IRWrite_o  = w_ir_write;
  assign bus.RegWrite_o = w_reg_write;
  assign bus.MemRead_o  = w_mem_read;
  assign bus.MemWrite_o = w_mem_write;
  assign bus.MemToReg_o = w_mem_to_reg;
  assign bus.ALUSrc_o   = w_alu_src;
  assign bus.IorD_o     = w_iord;
  assign bus.PCSrc_o    = w_pc_src;
  assign bus.ALUOp_o    = w_alu_op;
  assign bus.Busy_o     = (r_state != S_IDLE) && (r_state != S_TRAP);
  assign bus.Illegal_o  = r_illegal;
  assign bus.Timeout_o  = r_timeout;
  assign bus.State_o    = r_state;

endmodule

// File: tb/tb_control_seq.sv
// Directed bench for control_seq: dut_a (MUL_LATENCY=3, MEM_TIMEOUT=4) and
// dut_b (MUL_LATENCY=1, MEM_TIMEOUT=0), checked cycle by cycle at the falling edge.
module tb_control_seq;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  // {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, IorD, PCSrc, ALUOp[1:0]}
  localparam logic [10:0] V_NONE     = 11'b00000000000;
  localparam logic [10:0] V_FETCH    = 11'b11010000000;
  localparam logic [10:0] V_EXEC_IMM = 11'b00000010011;
  localparam logic [10:0] V_EXEC_REG = 11'b00000000010;
  localparam logic [10:0] V_EXEC_ST  = 11'b00000010000;
  localparam logic [10:0] V_MEM_LD   = 11'b00010011011;
  localparam logic [10:0] V_MEM_ST   = 11'b00001011000;
  localparam logic [10:0] V_WB       = 11'b00100000000;
  localparam logic [10:0] V_WB_LD    = 11'b00100100000;
  localparam logic [10:0] V_BR_T     = 11'b10000000110;
  localparam logic [10:0] V_BR_NT    = 11'b00000000110;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  control_seq_if ifa ();
  control_seq_if ifb ();

  control_seq #(.MUL_LATENCY(3), .MEM_TIMEOUT(4)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifa.master)
  );

  control_seq #(.MUL_LATENCY(1), .MEM_TIMEOUT(0)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifb.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] strobes(input bit sel);
    if (!sel)
      return {ifa.PCWrite_o, ifa.IRWrite_o, ifa.RegWrite_o, ifa.MemRead_o, ifa.MemWrite_o,
              ifa.MemToReg_o, ifa.ALUSrc_o, ifa.IorD_o, ifa.PCSrc_o, ifa.ALUOp_o};
    else
      return {ifb.PCWrite_o, ifb.IRWrite_o, ifb.RegWrite_o, ifb.MemRead_o, ifb.MemWrite_o,
              ifb.MemToReg_o, ifb.ALUSrc_o, ifb.IorD_o, ifb.PCSrc_o, ifb.ALUOp_o};
  endfunction

  // Check one cycle at the falling edge, then advance to just after the next rising edge.
  task automatic expect_cycle(input string tag, input bit sel, input logic [3:0] exp_state,
                              input logic [10:0] exp_vec);
    logic exp_busy;
    exp_busy = (exp_state != 4'd0) && (exp_state != 4'd8);
    @(negedge clk);
    if (!sel) begin
      check_eq({tag, "/state"}, 32'(ifa.State_o), 32'(exp_state));
      check_eq({tag, "/strb"},  32'(strobes(1'b0)), 32'(exp_vec));
      check_eq({tag, "/busy"},  32'(ifa.Busy_o), 32'(exp_busy));
    end else begin
      check_eq({tag, "/state"}, 32'(ifb.State_o), 32'(exp_state));
      check_eq({tag, "/strb"},  32'(strobes(1'b1)), 32'(exp_vec));
      check_eq({tag, "/busy"},  32'(ifb.Busy_o), 32'(exp_busy));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    ifa.Start_i = 1'b0; ifa.Opcode_i = 7'd0; ifa.Funct7_i = 7'd0;
    ifa.Zero_i = 1'b0;  ifa.MemReady_i = 1'b0;
    ifb.Start_i = 1'b0; ifb.Opcode_i = 7'd0; ifb.Funct7_i = 7'd0;
    ifb.Zero_i = 1'b0;  ifb.MemReady_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_cycle("rst_a", 1'b0, 4'd0, V_NONE);
    check_eq("rst_illegal", 32'(ifa.Illegal_o), 32'd0);
    check_eq("rst_timeout", 32'(ifa.Timeout_o), 32'd0);
    rst = 1'b0;

    // IMM then LOAD, memory always ready
    ifa.Start_i = 1'b1; ifa.MemReady_i = 1'b1; ifa.Opcode_i = OP_IMM;
    expect_cycle("imm_idle", 1'b0, 4'd0, V_NONE);
    expect_cycle("imm_f",    1'b0, 4'd1, V_FETCH);
    expect_cycle("imm_d",    1'b0, 4'd2, V_NONE);
    expect_cycle("imm_e",    1'b0, 4'd3, V_EXEC_IMM);
    expect_cycle("imm_wb",   1'b0, 4'd6, V_WB);
    ifa.Opcode_i = OP_LOAD;
    expect_cycle("ld_f",  1'b0, 4'd1, V_FETCH);
    expect_cycle("ld_d",  1'b0, 4'd2, V_NONE);
    expect_cycle("ld_e",  1'b0, 4'd3, V_EXEC_IMM);
    expect_cycle("ld_m",  1'b0, 4'd5, V_MEM_LD);
    expect_cycle("ld_wb", 1'b0, 4'd6, V_WB_LD);

    // M-extension OP with MUL_LATENCY=3: two MULW cycles
    ifa.Opcode_i = OP_OP; ifa.Funct7_i = 7'b0000001;
    expect_cycle("mul_f",  1'b0, 4'd1, V_FETCH);
    expect_cycle("mul_d",  1'b0, 4'd2, V_NONE);
    expect_cycle("mul_e",  1'b0, 4'd3, V_EXEC_REG);
    expect_cycle("mul_w1", 1'b0, 4'd4, V_EXEC_REG);
    expect_cycle("mul_w2", 1'b0, 4'd4, V_EXEC_REG);
    expect_cycle("mul_wb", 1'b0, 4'd6, V_WB);

    // plain OP
    ifa.Funct7_i = 7'b0100000;
    expect_cycle("op_f",  1'b0, 4'd1, V_FETCH);
    expect_cycle("op_d",  1'b0, 4'd2, V_NONE);
    expect_cycle("op_e",  1'b0, 4'd3, V_EXEC_REG);
    expect_cycle("op_wb", 1'b0, 4'd6, V_WB);

    // BRANCH taken then not taken
    ifa.Opcode_i = OP_BRANCH; ifa.Funct7_i = 7'd0; ifa.Zero_i = 1'b1;
    expect_cycle("brt_f", 1'b0, 4'd1, V_FETCH);
    expect_cycle("brt_d", 1'b0, 4'd2, V_NONE);
    expect_cycle("brt_b", 1'b0, 4'd7, V_BR_T);
    ifa.Zero_i = 1'b0;
    expect_cycle("brn_f", 1'b0, 4'd1, V_FETCH);
    expect_cycle("brn_d", 1'b0, 4'd2, V_NONE);
    expect_cycle("brn_b", 1'b0, 4'd7, V_BR_NT);

    // STORE with ready arriving on the 4th wait cycle: no trap
    ifa.Opcode_i = OP_STORE;
    expect_cycle("st_f", 1'b0, 4'd1, V_FETCH);
    expect_cycle("st_d", 1'b0, 4'd2, V_NONE);
    expect_cycle("st_e", 1'b0, 4'd3, V_EXEC_ST);
    ifa.MemReady_i = 1'b0;
    for (int i = 0; i < 3; i++) expect_cycle("st_wait", 1'b0, 4'd5, V_MEM_ST);
    ifa.MemReady_i = 1'b1;
    expect_cycle("st_m4", 1'b0, 4'd5, V_MEM_ST);

    // STORE with ready held low: trap after 4 wait cycles
    expect_cycle("sto_f", 1'b0, 4'd1, V_FETCH);
    check_eq("no_timeout", 32'(ifa.Timeout_o), 32'd0);
    expect_cycle("sto_d", 1'b0, 4'd2, V_NONE);
    expect_cycle("sto_e", 1'b0, 4'd3, V_EXEC_ST);
    ifa.MemReady_i = 1'b0;
    for (int i = 0; i < 4; i++) expect_cycle("sto_wait", 1'b0, 4'd5, V_MEM_ST);
    expect_cycle("sto_trap", 1'b0, 4'd8, V_NONE);
    check_eq("timeout_set", 32'(ifa.Timeout_o), 32'd1);
    check_eq("timeout_ill", 32'(ifa.Illegal_o), 32'd0);
    ifa.MemReady_i = 1'b1;
    expect_cycle("sto_hold", 1'b0, 4'd8, V_NONE);

    rst = 1'b1;
    #1;
    check_eq("rst_clr_to", 32'(ifa.Timeout_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // reset asserted mid-LOAD in MEM
    ifa.Opcode_i = OP_LOAD;
    expect_cycle("rl_idle", 1'b0, 4'd0, V_NONE);
    expect_cycle("rl_f",    1'b0, 4'd1, V_FETCH);
    expect_cycle("rl_d",    1'b0, 4'd2, V_NONE);
    expect_cycle("rl_e",    1'b0, 4'd3, V_EXEC_IMM);
    ifa.MemReady_i = 1'b0;
    expect_cycle("rl_m1",   1'b0, 4'd5, V_MEM_LD);
    #2;
    check_eq("rl_m2_rd", 32'(ifa.MemRead_o), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rl_async_strb",  32'(strobes(1'b0)), 32'(V_NONE));
    check_eq("rl_async_state", 32'(ifa.State_o), 32'd0);
    @(posedge clk);
    #1;
    check_eq("rl_busy", 32'(ifa.Busy_o), 32'd0);
    ifa.MemReady_i = 1'b1;
    rst = 1'b0;

    // illegal opcode: absorbing TRAP, Start_i toggles ignored
    ifa.Opcode_i = OP_BAD;
    expect_cycle("ill_idle", 1'b0, 4'd0, V_NONE);
    expect_cycle("ill_f",    1'b0, 4'd1, V_FETCH);
    expect_cycle("ill_d",    1'b0, 4'd2, V_NONE);
    expect_cycle("ill_trap", 1'b0, 4'd8, V_NONE);
    check_eq("ill_flag", 32'(ifa.Illegal_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      ifa.Start_i = ~ifa.Start_i;
      expect_cycle("ill_hold", 1'b0, 4'd8, V_NONE);
      check_eq("ill_sticky", 32'(ifa.Illegal_o), 32'd1);
    end
    check_eq("ill_no_to", 32'(ifa.Timeout_o), 32'd0);

    // dut_b: M-extension OP with MUL_LATENCY=1 takes 4 cycles
    ifb.Start_i = 1'b1; ifb.MemReady_i = 1'b1;
    ifb.Opcode_i = OP_OP; ifb.Funct7_i = 7'b0000001;
    expect_cycle("b_idle",   1'b1, 4'd0, V_NONE);
    expect_cycle("b_mul_f",  1'b1, 4'd1, V_FETCH);
    expect_cycle("b_mul_d",  1'b1, 4'd2, V_NONE);
    expect_cycle("b_mul_e",  1'b1, 4'd3, V_EXEC_REG);
    expect_cycle("b_mul_wb", 1'b1, 4'd6, V_WB);

    // dut_b: LOAD, Start_i dropped mid-instruction, long wait with timeout disabled
    ifb.Opcode_i = OP_LOAD; ifb.Funct7_i = 7'd0;
    expect_cycle("b_ld_f", 1'b1, 4'd1, V_FETCH);
    ifb.Start_i = 1'b0;
    expect_cycle("b_ld_d", 1'b1, 4'd2, V_NONE);
    expect_cycle("b_ld_e", 1'b1, 4'd3, V_EXEC_IMM);
    ifb.MemReady_i = 1'b0;
    for (int i = 0; i < 10; i++) expect_cycle("b_ld_wait", 1'b1, 4'd5, V_MEM_LD);
    ifb.MemReady_i = 1'b1;
    expect_cycle("b_ld_m",   1'b1, 4'd5, V_MEM_LD);
    expect_cycle("b_ld_wb",  1'b1, 4'd6, V_WB_LD);
    expect_cycle("b_ld_end", 1'b1, 4'd0, V_NONE);
    check_eq("b_no_to", 32'(ifb.Timeout_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
